// File: rtl/ecc_pkg.sv
// ecc_pkg: status codes, phase encodings and the
// shared check-bit equations for the byte ECC code.
package ecc_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN      = 2'd0,
    ST_CORR_DATA  = 2'd1,
    ST_CORR_CHECK = 2'd2,
    ST_UNCORR     = 2'd3
  } status_t;

  typedef enum logic {
    PH_DATA  = 1'b0,
    PH_CHECK = 1'b1
  } phase_t;

  // Check bits for one data byte; the encoder uses the same equations.
  function automatic logic [5:0] ecc_check(
    input logic [7:0] d
  );
    logic [5:0] r;
    r[0] = d[0] ^ d[2] ^ d[4] ^ d[6];
    r[1] = d[1] ^ d[3] ^ d[5] ^ d[7];
    r[2] = d[0] ^ d[1] ^ d[4] ^ d[5];
    r[3] = d[2] ^ d[3] ^ d[6] ^ d[7];
    r[4] = d[0] ^ d[1] ^ d[2] ^ d[3];
    r[5] = d[4] ^ d[5] ^ d[6] ^ d[7];
    return r;
  endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome, classification
// and single-bit data correction for one codeword.
import ecc_pkg::*;

module ecc_syndrome (
  input  logic [7:0] d,
  input  logic [5:0] c,
  output logic [1:0] status,
  output logic [7:0] data_fix
);

  logic [5:0] syn;
  logic       pair_ok;
  logic [2:0] idx;

  // Syndrome and the data-bit position it points at.
  always_comb begin
    syn     = ecc_check(d) ^ c;
    pair_ok = (syn[0] ^ syn[1]) &
              (syn[2] ^ syn[3]) &
              (syn[4] ^ syn[5]);
    idx     = {syn[5], syn[3], syn[1]};
  end

  // Classify; a data error sets exactly one bit per check pair.
  always_comb begin
    status   = ST_UNCORR;
    data_fix = d;
    unique case (1'b1)
      (syn == 6'd0): status = ST_CLEAN;
      pair_ok: begin
        status   = ST_CORR_DATA;
        data_fix = d ^ (8'd1 << idx);
      end
      $onehot(syn): status = ST_CORR_CHECK;
      default: status = ST_UNCORR;
    endcase
  end

endmodule

// File: rtl/ecc_decode.sv
// ecc_decode: two-byte codeword decoder with a
// registered result and saturating error counters.
import ecc_pkg::*;

module ecc_decode #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic [1:0]         out_status,
  input  logic               clear_counts,
  output logic [COUNT_W-1:0] corr_count,
  output logic [COUNT_W-1:0] uncorr_count
);

  localparam logic [COUNT_W-1:0] CNT_ONE =
    {{(COUNT_W-1){1'b0}}, 1'b1};

  phase_t     phase;
  phase_t     phase_nx;
  logic [7:0] dbyte;
  logic       xfer;
  logic       chk_acc;
  logic [1:0] st;
  logic [7:0] fix;
  logic       corr_inc;
  logic       uncorr_inc;
  logic       unused_hi;

  // Check-byte bits [7:6] carry no information.
  assign unused_hi = ^in_byte[7:6];

  assign in_ready   = !(out_valid && !out_ready);
  assign xfer       = in_valid && in_ready;
  assign chk_acc    = xfer && (phase == PH_CHECK);
  assign corr_inc   = chk_acc &&
                      ((st == ST_CORR_DATA) ||
                       (st == ST_CORR_CHECK));
  assign uncorr_inc = chk_acc && (st == ST_UNCORR);

  ecc_syndrome u_syn (
    .d        (dbyte),
    .c        (in_byte[5:0]),
    .status   (st),
    .data_fix (fix)
  );

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) phase <= PH_DATA;
    else       phase <= phase_nx;
  end

  // Phase advances on every accepted byte.
  always_comb begin
    phase_nx = phase;
    if (xfer) begin
      case (phase)
        PH_DATA:  phase_nx = PH_CHECK;
        PH_CHECK: phase_nx = PH_DATA;
        default:  phase_nx = PH_DATA;
      endcase
    end
  end

  // Capture the data byte while waiting for its check byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dbyte <= 8'h00;
    else if (xfer && phase == PH_DATA)
      dbyte <= in_byte;
  end

  // Result register; a new load wins over a retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_status <= ST_CLEAN;
    end else if (chk_acc) begin
      out_valid  <= 1'b1;
      out_data   <= fix;
      out_status <= st;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Corrected-error counter, saturating; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      corr_count <= '0;
    else if (clear_counts)
      corr_count <= '0;
    else if (corr_inc && corr_count != '1)
      corr_count <= corr_count + CNT_ONE;
  end

  // Uncorrectable-error counter, saturating; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      uncorr_count <= '0;
    else if (clear_counts)
      uncorr_count <= '0;
    else if (uncorr_inc && uncorr_count != '1)
      uncorr_count <= uncorr_count + CNT_ONE;
  end

endmodule

// File: tb/tb_ecc_decode.sv
// tb_ecc_decode: scoreboard bench with a search-based
// reference decoder, directed cases and random traffic.
module tb_ecc_decode;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [1:0]    out_status;
  logic          clear_counts;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] uncorr_count;

  typedef struct {
    logic [7:0] d;
    logic [1:0] st;
    bit         clr;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_corr   = 0;
  int   exp_uncorr = 0;
  int   results    = 0;
  bit   rand_ready = 0;

  ecc_decode #(.COUNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_status   (out_status),
    .clear_counts (clear_counts),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  always #5 clk = ~clk;

  // Check bits built per data bit: bit i feeds one check of each
  // pair, chosen by bits 0, 1 and 2 of its index.
  function automatic logic [5:0] ref_chk(input logic [7:0] d);
    logic [5:0] r = 6'd0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        r[0 + (i & 1)]        = ~r[0 + (i & 1)];
        r[2 + ((i >> 1) & 1)] = ~r[2 + ((i >> 1) & 1)];
        r[4 + ((i >> 2) & 1)] = ~r[4 + ((i >> 2) & 1)];
      end
    end
    return r;
  endfunction

  // Decode by searching for the nearest valid codeword.
  function automatic exp_t ref_decode(
    input logic [7:0] d, input logic [7:0] cb, input bit clr
  );
    exp_t       e;
    logic [5:0] c = cb[5:0];
    logic [7:0] m;
    logic [5:0] cm;
    bit         found = 0;
    e.clr = clr;
    e.d   = d;
    e.st  = 2'd3;
    if (ref_chk(d) == c) begin
      e.st  = 2'd0;
      found = 1;
    end
    for (int i = 0; i < 8; i++) begin
      m = d ^ (8'd1 << i);
      if (!found && ref_chk(m) == c) begin
        e.st  = 2'd1;
        e.d   = m;
        found = 1;
      end
    end
    for (int j = 0; j < 6; j++) begin
      cm = c ^ (6'd1 << j);
      if (!found && ref_chk(d) == cm) begin
        e.st  = 2'd2;
        found = 1;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_corr   = 0;
      exp_uncorr = 0;
    end else if (out_valid && out_ready) begin
      results++;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_result: got 0x%0h required none",
                 out_data);
      end else begin
        e = q.pop_front();
        if (e.clr) begin
          exp_corr   = 0;
          exp_uncorr = 0;
        end else if (e.st == 2'd1 || e.st == 2'd2) begin
          if (exp_corr < MAXC) exp_corr++;
        end else if (e.st == 2'd3) begin
          if (exp_uncorr < MAXC) exp_uncorr++;
        end
        chk("out_data", int'(out_data), int'(e.d));
        chk("out_status", int'(out_status), int'(e.st));
        chk("corr_count", int'(corr_count), exp_corr);
        chk("uncorr_count", int'(uncorr_count), exp_uncorr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_byte(
    input logic [7:0] b, input logic clr,
    input bit push, input exp_t e
  );
    bit acc = 0;
    in_valid     = 1'b1;
    in_byte      = b;
    clear_counts = clr;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (push) q.push_back(e);
      end
      tick();
    end
    in_valid     = 1'b0;
    clear_counts = 1'b0;
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL accept: got in_ready 0 required 1");
    end
  endtask

  task automatic send_cw(
    input logic [7:0] d, input logic [7:0] cb, input bit clr
  );
    exp_t e = ref_decode(d, cb, clr);
    if (rand_ready) repeat ($urandom_range(0, 1)) tick();
    drive_byte(d, 1'b0, 0, e);
    drive_byte(cb, clr, 1, e);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
    tick();
    chk("drain_queue", q.size(), 0);
  endtask

  // Codeword with `nerr` distinct bit flips over the 14 code bits.
  task automatic rand_cw(input int nerr, input int lim,
                         output logic [7:0] d, output logic [7:0] cb);
    logic [13:0] w;
    int          a;
    int          b;
    d = 8'($urandom);
    w = {ref_chk(d), d};
    a = $urandom_range(0, lim - 1);
    b = (a + $urandom_range(1, lim - 1)) % lim;
    if (nerr >= 1) w[a] = ~w[a];
    if (nerr >= 2) w[b] = ~w[b];
    d  = w[7:0];
    cb = {2'($urandom), w[13:8]};
  endtask

  initial begin
    exp_t       none;
    logic [7:0] d;
    logic [7:0] cb;
    int         base;
    none.d = 8'h00; none.st = 2'd0; none.clr = 0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_byte      = 8'h00;
    out_ready    = 1'b1;
    clear_counts = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_status", int'(out_status), 0);
    chk("rst_corr", int'(corr_count), 0);
    chk("rst_uncorr", int'(uncorr_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    tick();

    send_cw(8'hA5, 8'h00, 0);
    send_cw(8'hAD, 8'h00, 0);
    send_cw(8'hA5, 8'h04, 0);
    send_cw(8'hA6, 8'h00, 0);
    drain();

    out_ready = 1'b0;
    send_cw(8'h3C, {2'b11, ref_chk(8'h3C)}, 0);
    in_valid = 1'b1;
    in_byte  = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_out_data", int'(out_data), 'h3C);
      chk("stall_out_status", int'(out_status), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send_cw(8'h11, {2'b00, ref_chk(8'h11) ^ 6'h20}, 0);
    drain();

    drive_byte(8'hA5, 1'b0, 0, none);
    reset = 1'b1;
    #1;
    chk("async_rst_corr", int'(corr_count), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    base = results;
    send_cw(8'hAD, 8'h00, 0);
    drain();
    chk("midword_reset_results", results - base, 1);

    for (int n = 0; n < 260; n++) begin
      rand_cw(1, 8, d, cb);
      send_cw(d, cb, 0);
    end
    drain();
    chk("corr_saturated", int'(corr_count), MAXC);

    rand_cw(1, 8, d, cb);
    send_cw(d, cb, 1);
    drain();
    chk("clear_corr", int'(corr_count), 0);

    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      rand_cw($urandom_range(0, 2), 14, d, cb);
      send_cw(d, cb, 0);
    end
    rand_ready = 0;
    out_ready  = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
